l0_skew_buffer: RTL and testbench

- Parametrised L0 input buffer for the systolic array. It holds one FIFO per array row.
- All rows are written in parallel from one wide input word.
- Rows are read with a programmable diagonal skew (row i lags row 0 by i*skew cycles), or all together in broadcast mode.
- Adds per-row output valids, empty-row read suppression, an aggregate empty flag and an occupancy count. Sits between the activation/weight SRAM and the PE array west edge.

---
 rtl/l0_pkg.sv | 21 ++
 rtl/l0_skew_buffer_if.sv | 32 +++
 rtl/l0_row_fifo.sv | 57 +++++
 rtl/l0_skew_buffer.sv | 68 ++++++
 tb/tb_l0_skew_buffer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/l0_pkg.sv
// Shared definitions for the L0 skew buffer: pointer-width helper and read-mode encodings.
package l0_pkg;

    typedef enum logic {
        MODE_SKEW  = 1'b0,
        MODE_BCAST = 1'b1
    } mode_e;

    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/l0_skew_buffer_if.sv
// Write/read bus between the SRAM-side driver (master) and the L0 skew buffer (slave).
interface l0_skew_buffer_if #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
);
    import l0_pkg::*;

    localparam int cw = clog2(depth) + 1;

    logic [row*bw-1:0] in;
    logic              wr;
    logic              rd;
    logic              mode;
    logic [row*bw-1:0] out;
    logic [row-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
    logic [cw-1:0]     o_count;

    modport master (
        output in, wr, rd, mode,
        input  out, o_valid, o_full, o_ready, o_empty, o_count
    );

    modport slave (
        input  in, wr, rd, mode,
        output out, o_valid, o_full, o_ready, o_empty, o_count
    );

endinterface

// File: rtl/l0_row_fifo.sv
// Single-row FIFO with registered read data and a one-cycle valid pulse per successful read.
module l0_row_fifo
    import l0_pkg::*;
#(
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [bw-1:0]          in,
    output logic [bw-1:0]          out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [clog2(depth):0]  o_count
);

    localparam int aw = clog2(depth);

    logic [aw:0]   wr_ptr;
    logic [aw:0]   rd_ptr;
    logic [bw-1:0] mem [depth];
    logic          wr_en;
    logic          rd_en;

    // Extra MSB on each pointer separates full from empty when the index bits match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign o_count = wr_ptr - rd_ptr;
    assign wr_en   = wr && !o_full;
    assign rd_en   = rd && !o_empty;

    // NOTE: storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[aw-1:0]] <= in;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= rd_en;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                out    <= mem[rd_ptr[aw-1:0]];
            end
        end
    end

endmodule

// File: rtl/l0_skew_buffer.sv
// L0 input buffer for the systolic array west edge: one FIFO per row, diagonal or broadcast reads.
module l0_skew_buffer
    import l0_pkg::*;
#(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64,
    parameter int skew  = 1
) (
    input  logic             clk,
    input  logic             reset,
    l0_skew_buffer_if.slave  bus
);

    localparam int plen = (row - 1) * skew + 1;
    localparam int cw   = clog2(depth) + 1;

    logic [plen-1:0] skew_pipe;
    logic            bcast_q;
    logic            skew_launch;
    logic [row-1:0]  rd_req;
    logic [row-1:0]  row_full;
    logic [row-1:0]  row_empty;
    logic [cw-1:0]   row_count [row];
    logic            full_any;
    logic            wr_ok;

    assign full_any    = |row_full;
    assign wr_ok       = bus.wr && !full_any;
    assign skew_launch = bus.rd && (bus.mode == MODE_SKEW);

    // Broadcast waves bypass the shift register so they never re-fire down the diagonal later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skew_pipe <= '0;
            bcast_q   <= 1'b0;
        end else begin
            skew_pipe <= (skew_pipe << 1) | plen'(skew_launch);
            bcast_q   <= bus.rd && (bus.mode == MODE_BCAST);
        end
    end

    for (genvar i = 0; i < row; i++) begin : g_row
        assign rd_req[i] = skew_pipe[i*skew] || bcast_q;

        l0_row_fifo #(
            .bw    (bw),
            .depth (depth)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_ok),
            .rd      (rd_req[i]),
            .in      (bus.in[bw*i +: bw]),
            .out     (bus.out[bw*i +: bw]),
            .o_valid (bus.o_valid[i]),
            .o_full  (row_full[i]),
            .o_empty (row_empty[i]),
            .o_count (row_count[i])
        );
    end

    assign bus.o_full  = full_any;
    assign bus.o_ready = !full_any;
    assign bus.o_empty = &row_empty;
    assign bus.o_count = row_count[0];

endmodule

// File: tb/tb_l0_skew_buffer.sv
// Self-checking bench for l0_skew_buffer: vector table plus a behavioural per-row queue model.
module tb_l0_skew_buffer;
    import l0_pkg::*;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int SKEW  = 1;
    localparam int W     = ROW * BW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    l0_skew_buffer_if #(.row(ROW), .bw(BW), .depth(DEPTH)) bus ();

    l0_skew_buffer #(.row(ROW), .bw(BW), .depth(DEPTH), .skew(SKEW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: per-row contents plus a scoreboard of scheduled row reads.
    typedef struct {
        int edge_no;
        int row_idx;
    } rd_ev_t;

    logic [BW-1:0]  mq [ROW][$];
    rd_ev_t         sb [$];
    logic [W-1:0]   exp_out;
    logic [ROW-1:0] exp_valid;
    int             edge_cnt;

    function automatic bit m_full();
        bit f = 1'b0;
        for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) f = 1'b1;
        return f;
    endfunction

    function automatic bit m_empty();
        bit e = 1'b1;
        for (int i = 0; i < ROW; i++) if (mq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ROW; i++) mq[i].delete();
        sb.delete();
        exp_out   = '0;
        exp_valid = '0;
        edge_cnt  = 0;
    endtask

    task automatic model_edge(input bit w, input bit r, input bit m, input logic [W-1:0] d);
        rd_ev_t keep [$];
        bit     was_full;
        int     ri;
        edge_cnt++;
        was_full  = m_full();
        exp_valid = '0;
        foreach (sb[k]) begin
            if (sb[k].edge_no == edge_cnt) begin
                ri = sb[k].row_idx;
                if (mq[ri].size() > 0) begin
                    exp_out[ri*BW +: BW] = mq[ri].pop_front();
                    exp_valid[ri]        = 1'b1;
                end
            end else begin
                keep.push_back(sb[k]);
            end
        end
        sb = keep;
        if (w && !was_full) for (int i = 0; i < ROW; i++) mq[i].push_back(d[i*BW +: BW]);
        if (r) for (int i = 0; i < ROW; i++) sb.push_back('{edge_cnt + 1 + (m ? 0 : i * SKEW), i});
    endtask

    task automatic tick(input bit w, input bit r, input bit m, input logic [W-1:0] d);
        bus.wr   = w;
        bus.rd   = r;
        bus.mode = m;
        bus.in   = d;
        @(posedge clk);
        model_edge(w, r, m, d);
        @(negedge clk);
        check("out",     bus.out,     exp_out);
        check("o_valid", bus.o_valid, exp_valid);
        check("o_count", bus.o_count, mq[0].size());
        check("o_empty", bus.o_empty, m_empty());
        check("o_full",  bus.o_full,  m_full());
        check("o_ready", bus.o_ready, !m_full());
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", bus.o_valid, '0);
        check("rst_out",   bus.out,     '0);
        check("rst_empty", bus.o_empty, 1'b1);
        check("rst_full",  bus.o_full,  1'b0);
        check("rst_ready", bus.o_ready, 1'b1);
        check("rst_count", bus.o_count, 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit             do_rst;
        bit             wr;
        bit             rd;
        bit             mode;
        logic [W-1:0]   din;
        logic [ROW-1:0] ev;
        logic [W-1:0]   eo;
        int             ec;
    } vec_t;

    vec_t         vt [19];
    logic [W-1:0] saved_out;
    logic [W-1:0] d;
    bit           saw_ff;
    int           max_cnt;

    initial begin
        // Skew mode: one wave walks the diagonal one row per cycle.
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h76543210, 8'h00, 32'h00000000, 1};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h87654321, 8'h00, 32'h00000000, 2};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h98765432, 8'h00, 32'h00000000, 3};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        8'h00, 32'h00000000, 3};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h01, 32'h00000000, 2};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h02, 32'h00000010, 2};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h04, 32'h00000210, 2};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h08, 32'h00003210, 2};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h10, 32'h00043210, 2};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h20, 32'h00543210, 2};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h40, 32'h06543210, 2};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h80, 32'h76543210, 2};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        8'h00, 32'h76543210, 2};
        // Broadcast mode: every row returns its head together.
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00, 32'h00000000, 1};
        vt[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h87654321, 8'h00, 32'h00000000, 2};
        vt[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h98765432, 8'h00, 32'h00000000, 3};
        vt[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        8'h00, 32'h00000000, 3};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        8'hFF, 32'h76543210, 2};
        vt[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        8'h00, 32'h76543210, 2};

        bus.in   = '0;
        bus.wr   = 1'b0;
        bus.rd   = 1'b0;
        bus.mode = 1'b0;
        model_clear();
        #2;

        foreach (vt[k]) begin
            if (vt[k].do_rst) apply_reset();
            tick(vt[k].wr, vt[k].rd, vt[k].mode, vt[k].din);
            check($sformatf("vec%0d_valid", k), bus.o_valid, vt[k].ev);
            check($sformatf("vec%0d_out", k),   bus.out,     vt[k].eo);
            check($sformatf("vec%0d_count", k), bus.o_count, vt[k].ec);
        end

        // Fill to full, then a dropped write that must never surface.
        apply_reset();
        for (int k = 0; k < DEPTH; k++) begin
            d = W'(32'h11111111 * (k % 15));
            tick(1'b1, 1'b0, 1'b1, d);
        end
        check("full_flag",  bus.o_full,  1'b1);
        check("full_ready", bus.o_ready, 1'b0);
        check("full_count", bus.o_count, DEPTH);
        tick(1'b1, 1'b0, 1'b1, '1);
        check("drop_count", bus.o_count, DEPTH);
        saw_ff = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick(1'b0, 1'b1, 1'b1, '0);
            if (bus.out == '1) saw_ff = 1'b1;
        end
        tick(1'b0, 1'b0, 1'b1, '0);
        if (bus.out == '1) saw_ff = 1'b1;
        check("drop_never_read", saw_ff, 1'b0);
        check("drain_empty",     bus.o_empty, 1'b1);

        // Read of an all-empty buffer is suppressed on every row.
        saved_out = bus.out;
        tick(1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < ROW + 1; k++) begin
            tick(1'b0, 1'b0, 1'b0, '0);
            check("empty_rd_valid", bus.o_valid, '0);
        end
        check("empty_rd_out",   bus.out,     saved_out);
        check("empty_rd_count", bus.o_count, 0);

        // Interleaved write/read at occupancy ~1 carries the pointers across wrap.
        max_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1'b1, 1'b1, 1'b1, W'($urandom));
            if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
        end
        tick(1'b0, 1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, 1'b1, '0);
        check("wrap_max_count", max_cnt <= 2, 1'b1);
        check("wrap_end_empty", bus.o_empty, 1'b1);

        // Reset two cycles into a skewed wave kills the wave and the data.
        apply_reset();
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0, W'(32'h01234567 + k));
        tick(1'b0, 1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, '0);
        check("midwave_valid", bus.o_valid, 8'h02);
        apply_reset();
        for (int k = 0; k < ROW + 2; k++) begin
            tick(1'b0, 1'b0, 1'b0, '0);
            check("post_rst_valid", bus.o_valid, '0);
        end
        check("post_rst_empty", bus.o_empty, 1'b1);
        check("post_rst_count", bus.o_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
